// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the dmem port.
// Stores to TX_ADDR feed a byte FIFO; loads from STAT_ADDR return status.
module mmio_uart_tx #(
    parameter int          CLK_DIV    = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] TX_ADDR    = 12'hFF0,
    parameter logic [11:0] STAT_ADDR  = 12'hFF1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_mmio,
    output logic        mmio_hit,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e             state_q,    state_d;
    logic [PTR_W-1:0]   head_q,     head_d;
    logic [PTR_W-1:0]   tail_q,     tail_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         shift_q,    shift_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q,  bit_idx_d;
    logic               uart_tx_q,  uart_tx_d;
    logic [31:0]        q_mmio_q,   q_mmio_d;
    logic               mmio_hit_q, mmio_hit_d;

    logic [7:0] mem_q [FIFO_DEPTH];

    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        stat_wr;
    logic        fifo_full;
    logic        fifo_nempty;
    logic        bit_end;
    logic        busy;
    logic [7:0]  cnt8;
    logic [31:0] status_word;
    logic        unused_data;

    assign push_req    = wren && (address_dmem == TX_ADDR);
    assign stat_wr     = wren && (address_dmem == STAT_ADDR);
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_nempty = (count_q != '0);
    assign bit_end     = (baud_cnt_q == BAUD_LAST);
    assign busy        = fifo_nempty || (state_q != IDLE);
    assign cnt8        = 8'(count_q);
    assign status_word = {21'b0, cnt8, overflow_q, fifo_full, busy};
    assign unused_data = |data[31:8];

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        uart_tx_d  = uart_tx_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                uart_tx_d = 1'b1;
                if (fifo_nempty) begin
                    pop        = 1'b1;
                    state_d    = START;
                    baud_cnt_d = '0;
                    uart_tx_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    uart_tx_d  = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        uart_tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        uart_tx_d = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Back-to-back frames: go straight to START, no idle gap
                    if (fifo_nempty) begin
                        pop       = 1'b1;
                        state_d   = START;
                        uart_tx_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        uart_tx_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                uart_tx_d = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d = mem_q[head_q];
            head_d  = head_q + PTR_ONE;
        end

        push_ok = push_req && (!fifo_full || pop);
        if (push_ok) begin
            tail_d = tail_q + PTR_ONE;
        end

        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Clear first so a same-cycle overflow wins
        if (stat_wr && data[2]) begin
            overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end

        q_mmio_d   = (address_dmem == STAT_ADDR) ? status_word : 32'd0;
        mmio_hit_d = (address_dmem == STAT_ADDR) ||
                     (address_dmem == TX_ADDR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            uart_tx_q  <= 1'b1;
            q_mmio_q   <= '0;
            mmio_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            uart_tx_q  <= uart_tx_d;
            q_mmio_q   <= q_mmio_d;
            mmio_hit_q <= mmio_hit_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[tail_q] <= data[7:0];
        end
    end

    assign q_mmio   = q_mmio_q;
    assign mmio_hit = mmio_hit_q;
    assign uart_tx  = uart_tx_q;
    assign tx_busy  = busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random traffic
// against a frame-level reference model.
module tb_mmio_uart_tx;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
    localparam logic [11:0] TXA   = 12'hFF0;
    localparam logic [11:0] STA   = 12'hFF1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_mmio;
    logic        mmio_hit;
    logic        uart_tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending bytes plus the byte on the wire
    logic [7:0]  mq[$];
    bit          m_active = 1'b0;
    int          m_fs = 0;
    int          m_edge = 0;
    logic [7:0]  m_cur = '0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_qmmio = '0;
    bit          m_hit = 1'b0;

    logic        samp[40];

    mmio_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH),
        .TX_ADDR    (TXA),
        .STAT_ADDR  (STA)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_mmio       (q_mmio),
        .mmio_hit     (mmio_hit),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy)
    );

    always #5 clock = ~clock;

    function automatic logic m_line();
        int k;
        if (!m_active) return 1'b1;
        k = (m_edge - m_fs) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("uart_tx", 32'(uart_tx), 32'(m_line()));
        chk("tx_busy", 32'(tx_busy), 32'(m_active || mq.size() > 0));
        chk("q_mmio", q_mmio, m_qmmio);
        chk("mmio_hit", 32'(mmio_hit), 32'(m_hit));
    endtask

    // One clock: drive inputs, advance model, check after the edge
    task automatic step(input logic [11:0] a, input logic [31:0] d,
                        input logic we);
        int n;
        bit mbusy;
        address_dmem = a;
        data = d;
        wren = we;
        n = mq.size();
        mbusy = m_active || n > 0;
        m_qmmio = (a == STA) ?
            {21'b0, 8'(n), m_ovf, (n == DEPTH), mbusy} : 32'd0;
        m_hit = (a == STA) || (a == TXA);
        m_edge++;
        if (m_active && m_edge == m_fs + 10 * DIV) m_active = 1'b0;
        if (!m_active && n > 0) begin
            m_cur = mq.pop_front();
            m_active = 1'b1;
            m_fs = m_edge;
        end
        if (we && a == STA && d[2]) m_ovf = 1'b0;
        if (we && a == TXA) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(12'h000, 32'd0, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_ovf = 1'b0;
        m_qmmio = '0;
        m_hit = 1'b0;
    endtask

    initial begin
        logic [9:0] seq;
        int r;

        // Reset state
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_q_mmio", q_mmio, 32'd0);
        chk("rst_hit", 32'(mmio_hit), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b1;

        // 1: single 0x55 frame, sampled mid-bit
        step(TXA, 32'h0000_0055, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(12'h000, 32'd0, 1'b0);
            samp[i] = uart_tx;
        end
        for (int j = 0; j < 10; j++) seq[j] = samp[4*j + 2];
        chk("t1_bits", 32'(seq), 32'h2AA);
        chk("t1_start_edge", 32'(samp[0]), 32'd0);
        step(12'h000, 32'd0, 1'b0);
        chk("t1_busy_done", 32'(tx_busy), 32'd0);

        // 2: two back-to-back frames
        step(TXA, 32'h0000_00A3, 1'b1);
        step(TXA, 32'h0000_000F, 1'b1);
        idle(85);

        // 3: overflow with ten stores
        for (int i = 0; i < 10; i++) step(TXA, 32'(8'h30 + i), 1'b1);
        step(STA, 32'd0, 1'b0);
        chk("t3_ovf_full", 32'(q_mmio[2:1]), 32'd3);
        chk("t3_count", 32'(q_mmio[10:3]), 32'd8);
        step(STA, 32'h4, 1'b1);
        step(STA, 32'd0, 1'b0);
        chk("t3_ovf_clr", 32'(q_mmio[2]), 32'd0);
        idle(9 * 40 + 5);

        // 4: status while idle, then with 3 queued
        step(STA, 32'd0, 1'b0);
        chk("t4_idle_q", q_mmio, 32'd0);
        chk("t4_idle_hit", 32'(mmio_hit), 32'd1);
        for (int i = 0; i < 4; i++) step(TXA, 32'(8'hC0 + i), 1'b1);
        step(STA, 32'd0, 1'b0);
        chk("t4_busy_cnt", q_mmio, 32'h19);
        idle(4 * 40 + 5);

        // 5: reset in the middle of DATA
        step(TXA, 32'h0000_0000, 1'b1);
        step(TXA, 32'h0000_0081, 1'b1);
        idle(12);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t5_line", 32'(uart_tx), 32'd1);
        chk("t5_busy", 32'(tx_busy), 32'd0);
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
        idle(50);

        // 6: dmem-only address
        step(12'h010, 32'h0000_00EE, 1'b1);
        step(12'h010, 32'd0, 1'b0);
        chk("t6_hit", 32'(mmio_hit), 32'd0);
        chk("t6_q", q_mmio, 32'd0);
        chk("t6_busy", 32'(tx_busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(99);
            if (r < 25)
                step(TXA, $urandom, 1'b1);
            else if (r < 40)
                step(STA, $urandom, 1'b0);
            else if (r < 45)
                step(STA, $urandom, 1'b1);
            else if (r < 50)
                step(12'($urandom), $urandom, 1'($urandom));
            else
                step(12'h000, 32'd0, 1'b0);
        end
        idle(9 * 40 + 5);
        step(STA, 32'd0, 1'b0);
        chk("final_busy", 32'(q_mmio[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
